// File: rtl/up_down_counter_core.sv
// up_down_counter_core
//   WIDTH-bit registered up/down counter. It handles the mode and data-load
//   interface, and provides wrap or saturation handling, carry/borrow event
//   pulses, a registered mode tracker and a saturating wrap-event counter.
//
//   state | meaning
//   ------+----------------------------------------------
//   HOLD  | count unchanged
//   INC   | count += STEP, carry on overflow
//   DEC   | count -= STEP, borrow on underflow
//   LOAD  | count = data_in, no carry/borrow
//
// Ports
//   clk_in       : clock, all state updates on the rising edge
//   reset_in     : asynchronous active-high reset
//   s_in         : mode 00 HOLD, 01 INC, 10 DEC, 11 LOAD
//   data_in      : load value, sampled when s_in = 11
//   clr_wrap_in  : synchronous clear of wrap_count (wins over an event)
//   data_out     : registered count
//   carry_out    : one-cycle pulse, increment went past max
//   borrow_out   : one-cycle pulse, decrement went below 0
//   tc_max       : registered, data_out == all ones
//   tc_min       : registered, data_out == 0
//   mode_out     : mode applied on the last edge
//   mode_changed : one-cycle pulse when mode_out changes
//   wrap_count   : saturating count of carry + borrow events
module up_down_counter_core #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [1:0]       s_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_wrap_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             tc_max,
  output logic             tc_min,
  output logic [1:0]       mode_out,
  output logic             mode_changed,
  output logic [15:0]      wrap_count
);

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    INC  = 2'b01,
    DEC  = 2'b10,
    LOAD = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX_VAL};
  localparam logic [15:0]      WRAP_MAX = 16'hFFFF;

  mode_t            mode_q;
  mode_t            mode_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] count_next;
  logic             carry_next;
  logic             borrow_next;

  assign mode_next = mode_t'(s_in);
  assign mode_out  = mode_q;

  always_comb begin
    // Extra bit on the sum makes overflow a plain magnitude compare.
    sum         = {1'b0, data_out} + {1'b0, STEP_VAL};
    count_next  = data_out;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    case (mode_next)
      INC: begin
        if (sum > MAX_EXT) begin
          carry_next = 1'b1;
          count_next = (SATURATE != 0) ? MAX_VAL : sum[WIDTH-1:0];
        end else begin
          count_next = sum[WIDTH-1:0];
        end
      end
      DEC: begin
        if (data_out >= STEP_VAL) begin
          count_next = data_out - STEP_VAL;
        end else begin
          borrow_next = 1'b1;
          // Unsigned subtraction already yields the modulo result.
          count_next  = (SATURATE != 0) ? '0 : data_out - STEP_VAL;
        end
      end
      LOAD:    count_next = data_in;
      default: count_next = data_out;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      data_out     <= '0;
      carry_out    <= 1'b0;
      borrow_out   <= 1'b0;
      tc_max       <= 1'b0;
      tc_min       <= 1'b1;
      mode_q       <= HOLD;
      mode_changed <= 1'b0;
      wrap_count   <= '0;
    end else begin
      data_out     <= count_next;
      carry_out    <= carry_next;
      borrow_out   <= borrow_next;
      // Flags derive from the next count so they line up with data_out.
      tc_max       <= (count_next == MAX_VAL);
      tc_min       <= (count_next == '0);
      mode_q       <= mode_next;
      mode_changed <= (mode_next != mode_q);
      if (clr_wrap_in) begin
        wrap_count <= '0;
      end else if ((carry_next || borrow_next) && (wrap_count != WRAP_MAX)) begin
        wrap_count <= wrap_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_up_down_counter_core.sv
module tb_up_down_counter_core;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;

  logic [1:0]  s0 = 2'b00, s1 = 2'b00;
  logic [7:0]  d0 = 8'd0, d1 = 8'd0;
  logic        clr0 = 1'b0, clr1 = 1'b0;

  logic [7:0]  q0, q1;
  logic        carry0, carry1, borrow0, borrow1;
  logic        tmax0, tmax1, tmin0, tmin1;
  logic [1:0]  mode0, mode1;
  logic        mc0, mc1;
  logic [15:0] wrap0, wrap1;

  int checks = 0;
  int errors = 0;
  int exp_wrap0 = 0;
  int exp_wrap1 = 0;

  always #5 clk_in = ~clk_in;

  up_down_counter_core #(.WIDTH(8), .STEP(1), .SATURATE(0)) dut0 (
    .clk_in(clk_in), .reset_in(reset_in), .s_in(s0), .data_in(d0),
    .clr_wrap_in(clr0), .data_out(q0), .carry_out(carry0), .borrow_out(borrow0),
    .tc_max(tmax0), .tc_min(tmin0), .mode_out(mode0), .mode_changed(mc0),
    .wrap_count(wrap0)
  );

  up_down_counter_core #(.WIDTH(8), .STEP(3), .SATURATE(1)) dut1 (
    .clk_in(clk_in), .reset_in(reset_in), .s_in(s1), .data_in(d1),
    .clr_wrap_in(clr1), .data_out(q1), .carry_out(carry1), .borrow_out(borrow1),
    .tc_max(tmax1), .tc_min(tmin1), .mode_out(mode1), .mode_changed(mc1),
    .wrap_count(wrap1)
  );

  // Advance one rising edge and settle, so outputs are sampled away from it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_in);
    #1;
    checks++; if (q0 !== 8'd0)      begin errors++; $display("FAIL reset_data got %0d want 0", q0); end
    checks++; if (tmin0 !== 1'b1)   begin errors++; $display("FAIL reset_tc_min got %b want 1", tmin0); end
    checks++; if (tmax0 !== 1'b0)   begin errors++; $display("FAIL reset_tc_max got %b want 0", tmax0); end
    checks++; if ({carry0, borrow0, mc0} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {carry0, borrow0, mc0}); end
    checks++; if (mode0 !== 2'b00)  begin errors++; $display("FAIL reset_mode got %b want 00", mode0); end
    checks++; if (wrap0 !== 16'd0)  begin errors++; $display("FAIL reset_wrap got %0d want 0", wrap0); end
    reset_in = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] vals [4] = '{8'd200, 8'd245, 8'd0, 8'd255};
    for (int i = 0; i < 4; i++) begin
      s0 = 2'b11; d0 = vals[i];
      step();
      checks++; if (q0 !== vals[i]) begin errors++; $display("FAIL load_data got %0d want %0d", q0, vals[i]); end
      checks++; if ({carry0, borrow0} !== 2'b00) begin errors++; $display("FAIL load_cb got %b want 00", {carry0, borrow0}); end
      checks++; if (tmin0 !== (vals[i] == 8'd0)) begin errors++; $display("FAIL load_tc_min got %b for %0d", tmin0, vals[i]); end
      checks++; if (tmax0 !== (vals[i] == 8'd255)) begin errors++; $display("FAIL load_tc_max got %b for %0d", tmax0, vals[i]); end
      s0 = 2'b00; d0 = 8'd17;
      step();
      checks++; if (q0 !== vals[i]) begin errors++; $display("FAIL load_hold got %0d want %0d", q0, vals[i]); end
    end
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp;
    int carries;
    s0 = 2'b11; d0 = 8'd255;
    step();
    s0 = 2'b01;
    step();
    exp_wrap0++;
    checks++; if (q0 !== 8'd0)    begin errors++; $display("FAIL inc_wrap_data got %0d want 0", q0); end
    checks++; if (carry0 !== 1'b1) begin errors++; $display("FAIL inc_wrap_carry got %b want 1", carry0); end
    checks++; if (tmin0 !== 1'b1) begin errors++; $display("FAIL inc_wrap_tc_min got %b want 1", tmin0); end
    checks++; if (wrap0 !== 16'(exp_wrap0)) begin errors++; $display("FAIL inc_wrap_count got %0d want %0d", wrap0, exp_wrap0); end
    exp = 8'd0;
    carries = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp == 8'd255) begin carries++; exp_wrap0++; end
      exp = exp + 8'd1;
      checks++; if (q0 !== exp || carry0 !== (exp == 8'd0) || borrow0 !== 1'b0)
        begin errors++; $display("FAIL inc_run step %0d got %0d c%b b%b want %0d", i, q0, carry0, borrow0, exp); end
    end
    checks++; if (carries != 1) begin errors++; $display("FAIL inc_run_carries got %0d want 1", carries); end
    checks++; if (wrap0 !== 16'(exp_wrap0)) begin errors++; $display("FAIL inc_run_wrap got %0d want %0d", wrap0, exp_wrap0); end
  endtask

  task automatic test_dec_wrap();
    logic [7:0] exp;
    s0 = 2'b11; d0 = 8'd0;
    step();
    s0 = 2'b10;
    step();
    exp_wrap0++;
    checks++; if (q0 !== 8'd255)    begin errors++; $display("FAIL dec_wrap_data got %0d want 255", q0); end
    checks++; if (borrow0 !== 1'b1) begin errors++; $display("FAIL dec_wrap_borrow got %b want 1", borrow0); end
    checks++; if (tmax0 !== 1'b1)   begin errors++; $display("FAIL dec_wrap_tc_max got %b want 1", tmax0); end
    exp = 8'd255;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp == 8'd0) exp_wrap0++;
      exp = exp - 8'd1;
      checks++; if (q0 !== exp || borrow0 !== (exp == 8'd255) || carry0 !== 1'b0 || wrap0 !== 16'(exp_wrap0))
        begin errors++; $display("FAIL dec_run step %0d got %0d b%b w%0d want %0d w%0d", i, q0, borrow0, wrap0, exp, exp_wrap0); end
    end
  endtask

  task automatic test_hold();
    int pulses;
    s0 = 2'b11; d0 = 8'd40;
    step();
    s0 = 2'b01;
    repeat (5) step();
    checks++; if (q0 !== 8'd45) begin errors++; $display("FAIL hold_pre_inc got %0d want 45", q0); end
    s0 = 2'b00;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mc0 === 1'b1) pulses++;
      checks++; if (q0 !== 8'd45) begin errors++; $display("FAIL hold_inc step %0d got %0d want 45", i, q0); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_mode_changed got %0d pulses want 1", pulses); end
    checks++; if (mode0 !== 2'b00) begin errors++; $display("FAIL hold_mode got %b want 00", mode0); end
    s0 = 2'b11; d0 = 8'd205;
    step();
    checks++; if (mc0 !== 1'b1) begin errors++; $display("FAIL hold_mc_load got %b want 1", mc0); end
    s0 = 2'b10;
    repeat (5) step();
    s0 = 2'b00;
    repeat (4) step();
    checks++; if (q0 !== 8'd200) begin errors++; $display("FAIL hold_dec got %0d want 200", q0); end
    checks++; if (wrap0 !== 16'(exp_wrap0)) begin errors++; $display("FAIL hold_wrap got %0d want %0d", wrap0, exp_wrap0); end
  endtask

  task automatic test_saturate();
    s1 = 2'b11; d1 = 8'd10;
    step();
    s1 = 2'b01;
    step();
    checks++; if (q1 !== 8'd13 || carry1 !== 1'b0) begin errors++; $display("FAIL sat_step got %0d c%b want 13 c0", q1, carry1); end
    s1 = 2'b11; d1 = 8'd254;
    step();
    s1 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_wrap1++;
      checks++; if (q1 !== 8'd255 || carry1 !== 1'b1 || borrow1 !== 1'b0)
        begin errors++; $display("FAIL sat_inc step %0d got %0d c%b b%b want 255 c1 b0", i, q1, carry1, borrow1); end
    end
    checks++; if (tmax1 !== 1'b1) begin errors++; $display("FAIL sat_tc_max got %b want 1", tmax1); end
    s1 = 2'b11; d1 = 8'd2;
    step();
    s1 = 2'b10;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_wrap1++;
      checks++; if (q1 !== 8'd0 || borrow1 !== 1'b1 || carry1 !== 1'b0)
        begin errors++; $display("FAIL sat_dec step %0d got %0d b%b c%b want 0 b1 c0", i, q1, borrow1, carry1); end
    end
    checks++; if (wrap1 !== 16'(exp_wrap1)) begin errors++; $display("FAIL sat_wrap got %0d want %0d", wrap1, exp_wrap1); end
  endtask

  task automatic test_wrap_saturation();
    s1 = 2'b11; d1 = 8'd255;
    step();
    s1 = 2'b01;
    repeat (65540) step();
    checks++; if (wrap1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_sat got %h want ffff", wrap1); end
    clr1 = 1'b1;
    step();
    checks++; if (wrap1 !== 16'd0 || carry1 !== 1'b1) begin errors++; $display("FAIL wrap_sat_clr got %0d c%b want 0 c1", wrap1, carry1); end
    clr1 = 1'b0;
    s1 = 2'b00;
  endtask

  task automatic test_clr_wrap();
    s0 = 2'b11; d0 = 8'd255;
    step();
    s0 = 2'b01; clr0 = 1'b1;
    step();
    checks++; if (q0 !== 8'd0 || carry0 !== 1'b1) begin errors++; $display("FAIL clr_carry got %0d c%b want 0 c1", q0, carry0); end
    checks++; if (wrap0 !== 16'd0) begin errors++; $display("FAIL clr_wrap got %0d want 0", wrap0); end
    clr0 = 1'b0;
    step();
    checks++; if (q0 !== 8'd1 || wrap0 !== 16'd0) begin errors++; $display("FAIL clr_after got %0d w%0d want 1 w0", q0, wrap0); end
  endtask

  task automatic test_async_reset();
    s0 = 2'b11; d0 = 8'd99;
    step();
    s0 = 2'b01;
    step();
    checks++; if (q0 !== 8'd100) begin errors++; $display("FAIL areset_pre got %0d want 100", q0); end
    #3 reset_in = 1'b1;
    #1;
    checks++; if (q0 !== 8'd0 || tmin0 !== 1'b1 || tmax0 !== 1'b0) begin errors++; $display("FAIL areset_data got %0d min%b max%b want 0 1 0", q0, tmin0, tmax0); end
    checks++; if (mode0 !== 2'b00 || mc0 !== 1'b0 || wrap0 !== 16'd0 || {carry0, borrow0} !== 2'b00)
      begin errors++; $display("FAIL areset_status got m%b mc%b w%0d cb%b want 00 0 0 00", mode0, mc0, wrap0, {carry0, borrow0}); end
    #2 reset_in = 1'b0;
    step();
    checks++; if (q0 !== 8'd1 || mode0 !== 2'b01 || mc0 !== 1'b1 || tmin0 !== 1'b0)
      begin errors++; $display("FAIL areset_resume got %0d m%b mc%b min%b want 1 01 1 0", q0, mode0, mc0, tmin0); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc_wrap();
    test_dec_wrap();
    test_hold();
    test_clr_wrap();
    test_saturate();
    test_wrap_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
